// File: rtl/timer_pkg.sv
// Shared constants for the 8-bit APB timer: widths, clock-select encodings,
// TCR/TSR bit positions and the prescaler terminal-count helper.
package timer_pkg;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  localparam logic [1:0] CKS_DIV2  = 2'd0;
  localparam logic [1:0] CKS_DIV4  = 2'd1;
  localparam logic [1:0] CKS_DIV8  = 2'd2;
  localparam logic [1:0] CKS_DIV16 = 2'd3;

  localparam int TCR_LOAD    = 0;
  localparam int TCR_DOWN    = 1;
  localparam int TCR_EN      = 2;
  localparam int TCR_CKS_LSB = 3;
  localparam int TCR_CKS_MSB = 4;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  // Last prescaler value of a period: divide-by (2 << cks) minus one.
  function automatic logic [PRE_W-1:0] pre_last(input logic [1:0] cks);
    logic [PRE_W-1:0] last;
    case (cks)
      CKS_DIV2:  last = 4'd1;
      CKS_DIV4:  last = 4'd3;
      CKS_DIV8:  last = 4'd7;
      CKS_DIV16: last = 4'd15;
      default:   last = 4'd1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock-select prescaler: emits a one-cycle tick every (2 << cks) qualifying
// cycles and restarts its period on disable, load or a clock-select change.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       pclk,
  input  logic       prst,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [1:0]       cks_q;
  logic [1:0]       cks_d;
  logic             restart_s;

  // Period restart has priority over the terminal count, so a cks change never ticks.
  always_comb begin
    restart_s = ~en | load | (cks != cks_q);
    cks_d     = cks;
    pre_d     = pre_q;
    tick      = 1'b0;
    if (restart_s) begin
      pre_d = {PRE_W{1'b0}};
    end else if (pre_q == pre_last(cks)) begin
      pre_d = {PRE_W{1'b0}};
      tick  = 1'b1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  // Prescaler state registers.
  always_ff @(posedge pclk) begin
    if (prst) begin
      pre_q <= {PRE_W{1'b0}};
      cks_q <= CKS_DIV2;
    end else begin
      pre_q <= pre_d;
      cks_q <= cks_d;
    end
  end

endmodule

// File: rtl/timer_count_core.sv
// Counting stage of the 8-bit APB timer: TCNT plus registered overflow/underflow
// set pulses that only a genuine counting step can raise.
module timer_count_core
  import timer_pkg::*;
(
  input  logic             pclk,
  input  logic             prst,
  input  logic             load,
  input  logic [WIDTH-1:0] tdr,
  input  logic             en,
  input  logic             down,
  input  logic [1:0]       cks,
  output logic [WIDTH-1:0] tcnt,
  output logic             ovf_set,
  output logic             udf_set
);

  logic             tick_s;
  logic [WIDTH-1:0] tcnt_q;
  logic [WIDTH-1:0] tcnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             udf_q;
  logic             udf_d;

  timer_prescaler u_prescaler (
    .pclk (pclk),
    .prst (prst),
    .en   (en),
    .load (load),
    .cks  (cks),
    .tick (tick_s)
  );

  // Load beats tick; a load never flags, whatever the old and new counts are.
  always_comb begin
    tcnt_d = tcnt_q;
    ovf_d  = 1'b0;
    udf_d  = 1'b0;
    if (load) begin
      tcnt_d = tdr;
    end else if (tick_s) begin
      if (down) begin
        tcnt_d = tcnt_q - WIDTH'(1);
        udf_d  = (tcnt_q == {WIDTH{1'b0}});
      end else begin
        tcnt_d = tcnt_q + WIDTH'(1);
        ovf_d  = (tcnt_q == {WIDTH{1'b1}});
      end
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  // Counter and flag registers.
  always_ff @(posedge pclk) begin
    if (prst) begin
      tcnt_q <= {WIDTH{1'b0}};
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign tcnt    = tcnt_q;
  assign ovf_set = ovf_q;
  assign udf_set = udf_q;

endmodule
